store_buffer: RTL and testbench

Posted-store buffer between the pipeline memory stage and the byte-addressed data memory. Accepts stores from the pipeline, queues them in a DEPTH-entry FIFO, and drains one entry per cycle onto the data memory write port. Loads pass through to the data memory read port; a load that overlaps a buffered store is either forwarded from the buffer or stalled until the conflict drains.

---
 rtl/store_buffer.sv | 181 ++++++++++++++++++
 tb/tb_store_buffer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Posted-store FIFO between the memory stage and data memory, with load overlap detection.
// Define STORE_FWD_EN to build the load-forwarding mux; otherwise any overlapping load stalls.
module store_buffer #(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          SYS_clk,
  input  logic          SYS_reset_n,
  input  logic          ST_valid,
  output logic          ST_ready,
  input  logic [1:0]    ST_length,
  input  logic [31:0]   ST_address,
  input  logic [31:0]   ST_data,
  input  logic          LD_valid,
  input  logic [1:0]    LD_length,
  input  logic          LD_signed,
  input  logic [31:0]   LD_address,
  output logic [31:0]   LD_data,
  output logic          LD_stall,
  input  logic          DRAIN_en,
  output logic          SB_empty,
  output logic [CW-1:0] SB_count,
  output logic [1:0]    MEM_write_length,
  output logic [31:0]   MEM_write_address,
  output logic [31:0]   MEM_write_data,
  output logic [1:0]    MEM_read_length,
  output logic          MEM_read_signed,
  output logic [31:0]   MEM_read_address,
  input  logic [31:0]   MEM_read_data
);

  localparam int PW = $clog2(DEPTH);

  logic [1:0]       len_q  [DEPTH];
  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  logic push, pop;

  assign ST_ready = (count_q != CW'(DEPTH));
  assign SB_empty = (count_q == '0);
  assign SB_count = count_q;

  // A length-00 store is a no-op and never occupies an entry.
  assign push = ST_valid && ST_ready && (ST_length != 2'b00);
  assign pop  = DRAIN_en && !SB_empty;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        len_q[i]  <= 2'b00;
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (push) begin
        len_q[tail_q]   <= ST_length;
        addr_q[tail_q]  <= ST_address;
        data_q[tail_q]  <= ST_data;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
    end
  end

  always_comb begin
    MEM_write_length  = 2'b00;
    MEM_write_address = '0;
    MEM_write_data    = '0;
    if (pop) begin
      MEM_write_length  = len_q[head_q];
      MEM_write_address = addr_q[head_q];
      MEM_write_data    = data_q[head_q];
    end
  end

  assign MEM_read_length  = LD_length;
  assign MEM_read_signed  = LD_signed;
  assign MEM_read_address = LD_address;

  function automatic logic [32:0] range_end(input logic [31:0] a, input logic [1:0] len);
    logic [2:0] n;
    case (len)
      2'b01:   n = 3'd1;
      2'b10:   n = 3'd2;
      2'b11:   n = 3'd4;
      default: n = 3'd0;
    endcase
    return {1'b0, a} + 33'(n);
  endfunction

  // Scan oldest to youngest so the last hit recorded is the youngest overlap.
  logic          hit;
  logic [PW-1:0] scan_idx;
  logic [32:0]   ld_end;
`ifdef STORE_FWD_EN
  logic [PW-1:0] hit_idx;
`endif

  always_comb begin
    hit      = 1'b0;
    scan_idx = '0;
    ld_end   = range_end(LD_address, LD_length);
`ifdef STORE_FWD_EN
    hit_idx  = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_q + PW'(k);
      if (valid_q[scan_idx] && (LD_length != 2'b00) &&
          ({1'b0, addr_q[scan_idx]} < ld_end) &&
          ({1'b0, LD_address} < range_end(addr_q[scan_idx], len_q[scan_idx]))) begin
        hit = 1'b1;
`ifdef STORE_FWD_EN
        hit_idx = scan_idx;
`endif
      end
    end
  end

`ifdef STORE_FWD_EN
  logic        fwd_ok;
  logic [31:0] fwd_raw;
  logic [31:0] fwd_data;

  always_comb begin
    fwd_raw  = data_q[hit_idx];
    fwd_ok   = (addr_q[hit_idx] == LD_address) && (len_q[hit_idx] >= LD_length);
    fwd_data = fwd_raw;
    case (LD_length)
      2'b01:   fwd_data = {{24{LD_signed & fwd_raw[7]}}, fwd_raw[7:0]};
      2'b10:   fwd_data = {{16{LD_signed & fwd_raw[15]}}, fwd_raw[15:0]};
      default: fwd_data = fwd_raw;
    endcase
  end

  always_comb begin
    LD_data  = MEM_read_data;
    LD_stall = 1'b0;
    if (LD_valid && hit) begin
      if (fwd_ok) begin
        LD_data = fwd_data;
      end else begin
        LD_data  = '0;
        LD_stall = 1'b1;
      end
    end
  end
`else
  always_comb begin
    LD_data  = MEM_read_data;
    LD_stall = 1'b0;
    if (LD_valid && hit) begin
      LD_data  = '0;
      LD_stall = 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: load vector table against a known buffer state,
// plus sequences for full/drain, partial-overlap stall and reset mid-drain.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          SYS_clk;
  logic          SYS_reset_n;
  logic          ST_valid;
  logic          ST_ready;
  logic [1:0]    ST_length;
  logic [31:0]   ST_address;
  logic [31:0]   ST_data;
  logic          LD_valid;
  logic [1:0]    LD_length;
  logic          LD_signed;
  logic [31:0]   LD_address;
  logic [31:0]   LD_data;
  logic          LD_stall;
  logic          DRAIN_en;
  logic          SB_empty;
  logic [CW-1:0] SB_count;
  logic [1:0]    MEM_write_length;
  logic [31:0]   MEM_write_address;
  logic [31:0]   MEM_write_data;
  logic [1:0]    MEM_read_length;
  logic          MEM_read_signed;
  logic [31:0]   MEM_read_address;
  logic [31:0]   MEM_read_data;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .SYS_clk(SYS_clk), .SYS_reset_n(SYS_reset_n),
    .ST_valid(ST_valid), .ST_ready(ST_ready), .ST_length(ST_length),
    .ST_address(ST_address), .ST_data(ST_data),
    .LD_valid(LD_valid), .LD_length(LD_length), .LD_signed(LD_signed),
    .LD_address(LD_address), .LD_data(LD_data), .LD_stall(LD_stall),
    .DRAIN_en(DRAIN_en), .SB_empty(SB_empty), .SB_count(SB_count),
    .MEM_write_length(MEM_write_length), .MEM_write_address(MEM_write_address),
    .MEM_write_data(MEM_write_data),
    .MEM_read_length(MEM_read_length), .MEM_read_signed(MEM_read_signed),
    .MEM_read_address(MEM_read_address), .MEM_read_data(MEM_read_data)
  );

  // Clock and reset
  initial SYS_clk = 1'b0;
  always #5 SYS_clk = ~SYS_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Byte-addressed data memory model (low 8 address bits), initialised mem[i] = i
  logic [7:0] mem [256];
  logic [7:0] rb0, rb1, rb2, rb3;
  assign rb0 = mem[MEM_read_address[7:0]];
  assign rb1 = mem[MEM_read_address[7:0] + 8'd1];
  assign rb2 = mem[MEM_read_address[7:0] + 8'd2];
  assign rb3 = mem[MEM_read_address[7:0] + 8'd3];
  assign MEM_read_data =
    (MEM_read_length == 2'b01) ? {{24{MEM_read_signed & rb0[7]}}, rb0} :
    (MEM_read_length == 2'b10) ? {{16{MEM_read_signed & rb1[7]}}, rb1, rb0} :
                                 {rb3, rb2, rb1, rb0};

  // Scoreboard: expected memory writes {length, address, data} in order
  logic [65:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Write monitor samples mid-cycle, before the edge that pops the head entry
  always @(negedge SYS_clk) begin
    logic [65:0] e;
    logic [7:0]  a;
    if (MEM_write_length != 2'b00) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got len %0d addr 0x%08h data 0x%08h expected none",
                 MEM_write_length, MEM_write_address, MEM_write_data);
      end else begin
        e = exp_q.pop_front();
        if (e !== {MEM_write_length, MEM_write_address, MEM_write_data}) begin
          n_fail++;
          $display("FAIL write_order: got %0d/0x%08h/0x%08h expected %0d/0x%08h/0x%08h",
                   MEM_write_length, MEM_write_address, MEM_write_data,
                   e[65:64], e[63:32], e[31:0]);
        end
      end
      a = MEM_write_address[7:0];
      mem[a] = MEM_write_data[7:0];
      if (MEM_write_length != 2'b01) mem[a + 8'd1] = MEM_write_data[15:8];
      if (MEM_write_length == 2'b11) begin
        mem[a + 8'd2] = MEM_write_data[23:16];
        mem[a + 8'd3] = MEM_write_data[31:24];
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge SYS_clk);
    #1;
  endtask

  task automatic push_store(input logic [1:0] len, input logic [31:0] a, input logic [31:0] d,
                            input bit expect_acc);
    ST_valid   = 1'b1;
    ST_length  = len;
    ST_address = a;
    ST_data    = d;
    if (expect_acc) exp_q.push_back({len, a, d});
    tick();
    ST_valid = 1'b0;
  endtask

  task automatic set_load(input logic v, input logic [1:0] len, input logic sgn, input logic [31:0] a);
    LD_valid   = v;
    LD_length  = len;
    LD_signed  = sgn;
    LD_address = a;
    #1;
  endtask

  // Load vector table; ovl marks loads that overlap a held entry
  typedef struct {
    string       name;
    logic        v;
    logic [1:0]  len;
    logic        sgn;
    logic [31:0] addr;
    logic        ovl;
    logic [31:0] fdata;
    logic        fstall;
  } ld_vec_t;

  ld_vec_t vecs[15];

  initial begin
    logic [31:0] exp_d;
    logic        exp_s;
    int          n;

    vecs[0]  = '{"ld_w_10",      1, 2'b11, 0, 32'h10, 1, 32'hDEADBEEF, 0};
    vecs[1]  = '{"ld_h_10",      1, 2'b10, 0, 32'h10, 1, 32'h0000BEEF, 0};
    vecs[2]  = '{"ld_hs_10",     1, 2'b10, 1, 32'h10, 1, 32'hFFFFBEEF, 0};
    vecs[3]  = '{"ld_bs_10",     1, 2'b01, 1, 32'h10, 1, 32'hFFFFFFEF, 0};
    vecs[4]  = '{"ld_bs_20",     1, 2'b01, 1, 32'h20, 1, 32'hFFFFFF80, 0};
    vecs[5]  = '{"ld_bu_20",     1, 2'b01, 0, 32'h20, 1, 32'h00000080, 0};
    vecs[6]  = '{"ld_w_20_part", 1, 2'b11, 0, 32'h20, 1, 32'h0,        1};
    vecs[7]  = '{"ld_b_11_part", 1, 2'b01, 0, 32'h11, 1, 32'h0,        1};
    vecs[8]  = '{"ld_w_30_short",1, 2'b11, 0, 32'h30, 1, 32'h0,        1};
    vecs[9]  = '{"ld_h_30",      1, 2'b10, 0, 32'h30, 1, 32'h0000A55A, 0};
    vecs[10] = '{"ld_w_2c_adj",  1, 2'b11, 0, 32'h2C, 0, 32'h2F2E2D2C, 0};
    vecs[11] = '{"ld_w_2e_part", 1, 2'b11, 0, 32'h2E, 1, 32'h0,        1};
    vecs[12] = '{"ld_b_14_adj",  1, 2'b01, 0, 32'h14, 0, 32'h00000014, 0};
    vecs[13] = '{"ld_bs_80_mem", 1, 2'b01, 1, 32'h80, 0, 32'hFFFFFF80, 0};
    vecs[14] = '{"ld_invalid",   0, 2'b11, 0, 32'h10, 0, 32'h13121110, 0};

    for (int i = 0; i < 256; i++) mem[i] = i[7:0];

    SYS_reset_n = 1'b0;
    ST_valid = 1'b0; ST_length = 2'b00; ST_address = '0; ST_data = '0;
    LD_valid = 1'b1; LD_length = 2'b11; LD_signed = 1'b0; LD_address = 32'h10;
    DRAIN_en = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_st_ready", 32'(ST_ready), 32'd1);
    check("rst_sb_empty", 32'(SB_empty), 32'd1);
    check("rst_sb_count", 32'(SB_count), 32'd0);
    check("rst_wr_len", 32'(MEM_write_length), 32'd0);
    check("rst_wr_addr", MEM_write_address, 32'd0);
    check("rst_wr_data", MEM_write_data, 32'd0);
    check("rst_ld_stall", 32'(LD_stall), 32'd0);
    check("rst_ld_data", LD_data, 32'h13121110);

    SYS_reset_n = 1'b1;
    tick();

    push_store(2'b00, 32'h70, 32'h1234, 0);
    check("noop_count", 32'(SB_count), 32'd0);

    push_store(2'b11, 32'h10, 32'hDEADBEEF, 1);
    push_store(2'b01, 32'h20, 32'h00000080, 1);
    push_store(2'b10, 32'h30, 32'h0000A55A, 1);
    check("count_3", 32'(SB_count), 32'd3);
    check("no_drain_wr_len", 32'(MEM_write_length), 32'd0);

    for (int i = 0; i < 15; i++) begin
      set_load(vecs[i].v, vecs[i].len, vecs[i].sgn, vecs[i].addr);
`ifdef STORE_FWD_EN
      exp_d = vecs[i].fdata;
      exp_s = vecs[i].fstall;
`else
      exp_d = vecs[i].ovl ? 32'h0 : vecs[i].fdata;
      exp_s = vecs[i].ovl;
`endif
      check({vecs[i].name, "_data"}, LD_data, exp_d);
      check({vecs[i].name, "_stall"}, 32'(LD_stall), 32'(exp_s));
    end

    // Fill to DEPTH; youngest entry at 0x10 must win
    push_store(2'b11, 32'h10, 32'h11223344, 1);
    check("full_count", 32'(SB_count), 32'd4);
    check("full_ready", 32'(ST_ready), 32'd0);
    set_load(1, 2'b10, 0, 32'h10);
`ifdef STORE_FWD_EN
    check("youngest_data", LD_data, 32'h00003344);
    check("youngest_stall", 32'(LD_stall), 32'd0);
`else
    check("youngest_data", LD_data, 32'h0);
    check("youngest_stall", 32'(LD_stall), 32'd1);
`endif
    LD_valid = 1'b0;

    push_store(2'b11, 32'h40, 32'h55555555, 0);
    check("full_ignore_count", 32'(SB_count), 32'd4);

    // Push while full with a concurrent pop: push refused, count drops by one
    ST_valid = 1'b1; ST_length = 2'b11; ST_address = 32'h50; ST_data = 32'h99;
    DRAIN_en = 1'b1;
    #1;
    check("pushpop_ready", 32'(ST_ready), 32'd0);
    check("pushpop_wr_len", 32'(MEM_write_length), 32'd3);
    check("pushpop_wr_addr", MEM_write_address, 32'h10);
    check("pushpop_wr_data", MEM_write_data, 32'hDEADBEEF);
    tick();
    ST_valid = 1'b0;
    DRAIN_en = 1'b0;
    #1;
    check("pushpop_count", 32'(SB_count), 32'd3);
    check("pushpop_ready_after", 32'(ST_ready), 32'd1);

    DRAIN_en = 1'b1;
    n = 0;
    while (!SB_empty && n < 10) begin
      tick();
      n++;
    end
    DRAIN_en = 1'b0;
    check("drain_cycles", n, 32'd3);
    check("drain_empty", 32'(SB_empty), 32'd1);
    set_load(1, 2'b11, 0, 32'h10);
    check("mem_w_10", LD_data, 32'h11223344);
    set_load(1, 2'b01, 1, 32'h20);
    check("mem_bs_20", LD_data, 32'hFFFFFF80);

    // Partial overlap: stalls until the byte at 0x21 drains
    LD_valid = 1'b0;
    push_store(2'b01, 32'h21, 32'h0000005A, 1);
    set_load(1, 2'b11, 0, 32'h20);
    check("part_stall", 32'(LD_stall), 32'd1);
    check("part_data", LD_data, 32'h0);
    DRAIN_en = 1'b1;
    #1;
    check("part_stall_draining", 32'(LD_stall), 32'd1);
    n = 0;
    do begin
      tick();
      n++;
    end while (LD_stall && n < 8);
    DRAIN_en = 1'b0;
    check("part_resolve_cycles", n, 32'd1);
    check("part_resolved_stall", 32'(LD_stall), 32'd0);
    check("part_resolved_data", LD_data, 32'h23225A80);
    LD_valid = 1'b0;

    // Reset mid-drain with three entries: nothing further is written
    push_store(2'b11, 32'h60, 32'hA0A0A0A0, 0);
    push_store(2'b11, 32'h64, 32'hB0B0B0B0, 0);
    push_store(2'b11, 32'h68, 32'hC0C0C0C0, 0);
    check("pre_rst_count", 32'(SB_count), 32'd3);
    DRAIN_en = 1'b1;
    #1;
    check("pre_rst_wr_len", 32'(MEM_write_length), 32'd3);
    SYS_reset_n = 1'b0;
    #1;
    check("mid_rst_count", 32'(SB_count), 32'd0);
    check("mid_rst_empty", 32'(SB_empty), 32'd1);
    check("mid_rst_wr_len", 32'(MEM_write_length), 32'd0);
    repeat (3) tick();
    SYS_reset_n = 1'b1;
    repeat (4) tick();
    DRAIN_en = 1'b0;
    check("post_rst_count", 32'(SB_count), 32'd0);
    check("post_rst_ready", 32'(ST_ready), 32'd1);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
